serdes_channel_noise: RTL and testbench

//  Synthesizable error injector between eth_phy_10g serdes_tx_* and serdes_rx_* for loopback BER tests.

---
 rtl/serdes_channel_noise.sv | 130 +++++++++++++
 tb/tb_serdes_channel_noise.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_channel_noise.sv
// serdes_channel_noise: error injector between serdes tx and rx for loopback BER testing.
// Corrupts sync headers and flips single data bits from two free-running Galois LFSRs.
module serdes_channel_noise #(
    parameter int          DATA_WIDTH = 64,
    parameter int          HDR_WIDTH  = 2,
    parameter logic [31:0] HDR_SEED   = 32'hACE1_2468,
    parameter logic [31:0] DATA_SEED  = 32'h1357_BDF9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [HDR_WIDTH-1:0]  in_hdr,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [HDR_WIDTH-1:0]  out_hdr,
    input  logic [1:0]            cfg_mode,
    input  logic [31:0]           cfg_hdr_thresh,
    input  logic [31:0]           cfg_data_thresh,
    input  logic [7:0]            cfg_burst_len,
    input  logic [31:0]           cfg_total_blocks,
    input  logic                  stat_clear,
    output logic [31:0]           stat_blocks,
    output logic [31:0]           stat_hdr_errs,
    output logic [31:0]           stat_data_errs,
    output logic                  done
);
    localparam int          IW   = $clog2(DATA_WIDTH);
    localparam logic [31:0] TAPS = 32'h8020_0003;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                state_q, state_d;
    logic [7:0]            burst_cnt_q, burst_cnt_d;
    logic [31:0]           hdr_lfsr_q, hdr_lfsr_d;
    logic [31:0]           data_lfsr_q, data_lfsr_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [HDR_WIDTH-1:0]  out_hdr_q, out_hdr_d;
    logic [31:0]           blocks_q, blocks_d;
    logic [31:0]           hdr_errs_q, hdr_errs_d;
    logic [31:0]           data_errs_q, data_errs_d;
    logic                  done_q, done_d;
    logic                  active, hdr_hit, data_hit, hdr_corrupt, data_corrupt, in_burst, cnt_en;
    logic [7:0]            len_m1;
    logic [HDR_WIDTH-1:0]  hdr_mask;
    logic [DATA_WIDTH-1:0] data_mask;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 32'd0);
    endfunction

    always_comb begin
        active       = in_valid && !done_q && (cfg_mode != 2'd0);
        hdr_hit      = hdr_lfsr_q < cfg_hdr_thresh;
        data_hit     = data_lfsr_q < cfg_data_thresh;
        in_burst     = state_q == BURST;
        len_m1       = (cfg_burst_len == 8'd0) ? 8'd0 : cfg_burst_len - 8'd1;
        hdr_corrupt  = active && ((cfg_mode == 2'd3) ? (in_burst || hdr_hit) : hdr_hit);
        data_corrupt = active && data_hit;
        hdr_mask     = (cfg_mode == 2'd1) ? {HDR_WIDTH{1'b1}} : HDR_WIDTH'(1) << hdr_lfsr_q[31];
        data_mask    = DATA_WIDTH'(1) << data_lfsr_q[IW-1:0];
        state_d      = state_q;
        burst_cnt_d  = burst_cnt_q;
        if (active && cfg_mode == 2'd3) begin
            if (in_burst) begin
                burst_cnt_d = burst_cnt_q - 8'd1;
                state_d     = (burst_cnt_q == 8'd1) ? IDLE : BURST;
            end else if (hdr_hit) begin
                burst_cnt_d = len_m1;
                state_d     = (len_m1 != 8'd0) ? BURST : IDLE;
            end
        end
        // Leaving burst mode, finishing the budget or clearing always abandons a burst
        if (cfg_mode != 2'd3 || done_q || stat_clear) begin
            state_d     = IDLE;
            burst_cnt_d = 8'd0;
        end
        hdr_lfsr_d  = in_valid ? lfsr_next(hdr_lfsr_q) : hdr_lfsr_q;
        data_lfsr_d = in_valid ? lfsr_next(data_lfsr_q) : data_lfsr_q;
        out_valid_d = in_valid;
        out_hdr_d   = in_valid ? in_hdr ^ (hdr_corrupt ? hdr_mask : '0) : out_hdr_q;
        out_data_d  = in_valid ? in_data ^ (data_corrupt ? data_mask : '0) : out_data_q;
        cnt_en      = in_valid && !done_q;
        blocks_d    = stat_clear ? 32'd0 : sat_inc(blocks_q, cnt_en);
        hdr_errs_d  = stat_clear ? 32'd0 : sat_inc(hdr_errs_q, hdr_corrupt);
        data_errs_d = stat_clear ? 32'd0 : sat_inc(data_errs_q, data_corrupt);
        done_d      = !stat_clear && (done_q || (cnt_en && cfg_total_blocks != 32'd0 && blocks_d == cfg_total_blocks));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            burst_cnt_q <= 8'd0;
            hdr_lfsr_q  <= HDR_SEED;
            data_lfsr_q <= DATA_SEED;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_hdr_q   <= '0;
            blocks_q    <= 32'd0;
            hdr_errs_q  <= 32'd0;
            data_errs_q <= 32'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            hdr_lfsr_q  <= hdr_lfsr_d;
            data_lfsr_q <= data_lfsr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_hdr_q   <= out_hdr_d;
            blocks_q    <= blocks_d;
            hdr_errs_q  <= hdr_errs_d;
            data_errs_q <= data_errs_d;
            done_q      <= done_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_hdr        = out_hdr_q;
    assign stat_blocks    = blocks_q;
    assign stat_hdr_errs  = hdr_errs_q;
    assign stat_data_errs = data_errs_q;
    assign done           = done_q;
endmodule

// File: tb/tb_serdes_channel_noise.sv
// tb_serdes_channel_noise: directed bench for serdes_channel_noise with hand-computed expectations.
module tb_serdes_channel_noise;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic [1:0]  in_hdr;
    logic        out_valid;
    logic [63:0] out_data;
    logic [1:0]  out_hdr;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_hdr_thresh, cfg_data_thresh, cfg_total_blocks;
    logic [7:0]  cfg_burst_len;
    logic        stat_clear;
    logic [31:0] stat_blocks, stat_hdr_errs, stat_data_errs;
    logic        done;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] saved_hdr;
    logic [63:0] vec;

    serdes_channel_noise dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_hdr(in_hdr),
        .out_valid(out_valid), .out_data(out_data), .out_hdr(out_hdr), .cfg_mode(cfg_mode),
        .cfg_hdr_thresh(cfg_hdr_thresh), .cfg_data_thresh(cfg_data_thresh),
        .cfg_burst_len(cfg_burst_len), .cfg_total_blocks(cfg_total_blocks),
        .stat_clear(stat_clear), .stat_blocks(stat_blocks), .stat_hdr_errs(stat_hdr_errs),
        .stat_data_errs(stat_data_errs), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle at the falling edge; outputs for it are visible at the next falling edge
    task automatic send(input logic v, input logic [63:0] d, input logic [1:0] h);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_hdr   = h;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic clear();
        @(negedge clk);
        stat_clear = 1'b1;
        in_valid   = 1'b0;
        @(negedge clk);
        stat_clear = 1'b0;
    endtask

    task automatic chk_stats(input string tag, input logic [31:0] b, input logic [31:0] h, input logic [31:0] d);
        chk({tag, "_blocks"}, stat_blocks, b);
        chk({tag, "_hdr"}, stat_hdr_errs, h);
        chk({tag, "_data"}, stat_data_errs, d);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_hdr = 2'b00; cfg_mode = 2'd0;
        cfg_hdr_thresh = '0; cfg_data_thresh = '0; cfg_burst_len = 8'd0;
        cfg_total_blocks = '0; stat_clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_hdr", out_hdr, 0);
        chk("rst_done", done, 0);
        chk_stats("rst", 0, 0, 0);
        rst_n = 1'b1;

        // Seeds: data index 57 then 63; header flip bit 1 then bit 0
        cfg_mode = 2'd2; cfg_hdr_thresh = 32'hFFFF_FFFF; cfg_data_thresh = 32'hFFFF_FFFF;
        send(1'b1, 64'd0, 2'b10);
        chk("seed_data0", out_data, 64'h0200_0000_0000_0000);
        chk("seed_hdr0", out_hdr, 2'b00);
        chk("seed_valid", out_valid, 1);
        send(1'b1, 64'd0, 2'b10);
        chk("seed_data1", out_data, 64'h8000_0000_0000_0000);
        chk("seed_hdr1", out_hdr, 2'b11);
        chk_stats("seed", 2, 2, 2);

        // Clear with concurrent block: counters zero, block still corrupted
        @(negedge clk);
        stat_clear = 1'b1; in_valid = 1'b1; in_data = 64'd0; in_hdr = 2'b10;
        @(negedge clk);
        stat_clear = 1'b0; in_valid = 1'b0;
        chk("clr_pop", $countones(out_data), 1);
        chk("clr_hdr", out_hdr == 2'b00 || out_hdr == 2'b11, 1);
        chk_stats("clr", 0, 0, 0);

        // Mode 0: clean pass-through
        cfg_mode = 2'd0;
        clear();
        for (int i = 0; i < 100; i++) begin
            vec = {i[31:0], ~i[31:0]};
            send(1'b1, vec, 2'b10);
            chk("m0_data", out_data, vec);
            chk("m0_hdr", out_hdr, 2'b10);
        end
        send(1'b0, 64'hDEAD, 2'b01);
        chk("m0_gap_valid", out_valid, 0);
        chk("m0_gap_hold", out_data, {32'd99, ~32'd99});
        chk_stats("m0", 100, 0, 0);

        // Mode 1: invert both header bits
        cfg_mode = 2'd1; cfg_data_thresh = 32'd0;
        clear();
        for (int i = 0; i < 50; i++) begin
            send(1'b1, 64'h1234, 2'b10);
            chk("m1_hdr", out_hdr, 2'b01);
            chk("m1_data", out_data, 64'h1234);
        end
        chk_stats("m1", 50, 50, 0);

        // Mode 2, data-only hits
        cfg_mode = 2'd2; cfg_hdr_thresh = 32'd0; cfg_data_thresh = 32'hFFFF_FFFF;
        clear();
        for (int i = 0; i < 40; i++) begin
            send(1'b1, 64'd0, 2'b10);
            chk("m2_pop", $countones(out_data), 1);
            chk("m2_hdr", out_hdr, 2'b10);
        end
        chk_stats("m2", 40, 0, 40);

        // Mode 3 burst of 4 with a gap inside
        cfg_mode = 2'd3; cfg_data_thresh = 32'd0; cfg_burst_len = 8'd4;
        clear();
        cfg_hdr_thresh = 32'hFFFF_FFFF;
        send(1'b1, 64'd0, 2'b10);
        chk("b4_0", out_hdr == 2'b00 || out_hdr == 2'b11, 1);
        cfg_hdr_thresh = 32'd0;
        send(1'b1, 64'd0, 2'b10);
        chk("b4_1", out_hdr == 2'b00 || out_hdr == 2'b11, 1);
        send(1'b0, 64'd0, 2'b10);
        chk("b4_gap", out_valid, 0);
        send(1'b1, 64'd0, 2'b10);
        chk("b4_2", out_hdr == 2'b00 || out_hdr == 2'b11, 1);
        send(1'b1, 64'd0, 2'b10);
        chk("b4_3", out_hdr == 2'b00 || out_hdr == 2'b11, 1);
        send(1'b1, 64'd0, 2'b10);
        chk("b4_end", out_hdr, 2'b10);
        chk_stats("b4", 5, 4, 0);

        // Burst length 0 behaves as 1
        cfg_burst_len = 8'd0; cfg_hdr_thresh = 32'hFFFF_FFFF;
        send(1'b1, 64'd0, 2'b10);
        chk("b0_0", out_hdr == 2'b00 || out_hdr == 2'b11, 1);
        cfg_hdr_thresh = 32'd0;
        send(1'b1, 64'd0, 2'b10);
        chk("b0_1", out_hdr, 2'b10);

        // Leaving mode 3 abandons the burst
        cfg_burst_len = 8'd10; cfg_hdr_thresh = 32'hFFFF_FFFF;
        send(1'b1, 64'd0, 2'b10);
        cfg_hdr_thresh = 32'd0; cfg_mode = 2'd2;
        send(1'b1, 64'd0, 2'b10);
        chk("bx_m2", out_hdr, 2'b10);
        cfg_mode = 2'd3;
        send(1'b1, 64'd0, 2'b10);
        chk("bx_m3", out_hdr, 2'b10);

        // Block budget of 500 at ~1% header BER
        cfg_mode = 2'd2; cfg_hdr_thresh = 32'h028F_5C29; cfg_total_blocks = 32'd500;
        clear();
        for (int i = 0; i < 499; i++) send(1'b1, 64'd0, 2'b10);
        chk("bud_499_done", done, 0);
        chk("bud_499_blocks", stat_blocks, 499);
        send(1'b1, 64'd0, 2'b10);
        chk("bud_done", done, 1);
        chk("bud_blocks", stat_blocks, 500);
        chk("bud_hdr_range", stat_hdr_errs < 32'd30, 1);
        saved_hdr = stat_hdr_errs;
        cfg_hdr_thresh = 32'hFFFF_FFFF; cfg_data_thresh = 32'hFFFF_FFFF;
        for (int i = 0; i < 20; i++) begin
            send(1'b1, 64'h55, 2'b10);
            chk("bud_clean_hdr", out_hdr, 2'b10);
            chk("bud_clean_data", out_data, 64'h55);
        end
        chk_stats("bud_frozen", 500, saved_hdr, 0);
        clear();
        chk("bud_clr_done", done, 0);
        cfg_total_blocks = 32'd0;

        // Asynchronous reset mid-burst
        cfg_mode = 2'd3; cfg_burst_len = 8'd8; cfg_data_thresh = 32'd0;
        send(1'b1, 64'h77, 2'b10);
        send(1'b1, 64'h77, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_data", out_data, 0);
        chk("ar_hdr", out_hdr, 0);
        chk_stats("ar", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cfg_hdr_thresh = 32'd0;
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 64'h99, 2'b10);
            chk("ar_clean_hdr", out_hdr, 2'b10);
            chk("ar_clean_data", out_data, 64'h99);
            send(1'b0, 64'd0, 2'b01);
            chk("ar_gap", out_valid, 0);
        end

        // Seeds restored by reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cfg_data_thresh = 32'hFFFF_FFFF;
        send(1'b1, 64'd0, 2'b10);
        chk("ar_seed_data", out_data, 64'h0200_0000_0000_0000);
        chk("ar_seed_hdr", out_hdr, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
